// File: rtl/booth_mult_sched_pkg.sv
// Shared types and helpers for the round-robin scheduled Booth multiplier.
package booth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Booth recoding of {Q[0], E}; 2'b11 behaves like NOP
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;

    // Width of the iteration counter; never narrower than one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/booth_mult_sched_if.sv
// Request/response bundle between two operand sources, the shared multiplier and the product sink.
interface booth_mult_sched_if #(
    parameter int WIDTH = 4
);

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_x;
    logic [2*WIDTH-1:0] req_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_z;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z
    );

endinterface

// File: rtl/booth_mult_sched_step.sv
// One radix-2 Booth iteration: conditional add/subtract of sext(Y), then arithmetic shift of {A,Q,E}.
module booth_step
    import booth_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             e,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             e_next
);

    logic [WIDTH:0] y_ext;
    logic [WIDTH:0] sum;

    assign y_ext = {y[WIDTH-1], y};

    // Recode {Q[0],E}, update the accumulator, then shift the whole {A,Q,E} chain right
    always_comb begin
        case ({q[0], e})
            SUB:     sum = a - y_ext;
            ADD:     sum = a + y_ext;
            default: sum = a;
        endcase
        a_next = {sum[WIDTH], sum[WIDTH:1]};
        q_next = {sum[0], q[WIDTH-1:1]};
        e_next = q[0];
    end

endmodule

// File: rtl/booth_mult_sched.sv
// Two-requester round-robin front end around a sequential radix-2 Booth multiplier.
// Optional build macro: BOOTH_SCHED_STATS_EN adds per-requester 8-bit response counters.
module booth_mult_sched
    import booth_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    booth_mult_sched_if.slave  bus,
    output logic               busy
`ifdef BOOTH_SCHED_STATS_EN
    ,
    output logic [7:0]         stat_cnt0,
    output logic [7:0]         stat_cnt1
`endif
);

    localparam int unsigned   CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic               rr_ptr;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               e;
    logic [WIDTH-1:0]   y_reg;

    logic               rsp_valid_r;
    logic               rsp_id_r;
    logic [2*WIDTH-1:0] rsp_z_r;

    logic               grant_vld;
    logic               grant_id;
    logic [WIDTH-1:0]   sel_x;
    logic [WIDTH-1:0]   sel_y;

    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   q_next;
    logic               e_next;
    logic [2*WIDTH-1:0] prod_next;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a      (acc),
        .q      (q),
        .e      (e),
        .y      (y_reg),
        .a_next (acc_next),
        .q_next (q_next),
        .e_next (e_next)
    );

    assign prod_next = {acc_next[WIDTH-1:0], q_next};

    // Round-robin grant in IDLE; held off during reset so no requester sees a phantom accept
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr;
        if (state == IDLE && !rst) begin
            if (bus.req_valid[rr_ptr]) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr;
            end else if (bus.req_valid[~rr_ptr]) begin
                grant_vld = 1'b1;
                grant_id  = ~rr_ptr;
            end
        end
    end

    assign bus.req_ready = grant_vld ? (2'b01 << grant_id) : '0;
    assign sel_x         = bus.req_x[grant_id*WIDTH +: WIDTH];
    assign sel_y         = bus.req_y[grant_id*WIDTH +: WIDTH];

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_z     = rsp_z_r;

    // Control FSM with operand, accumulator and registered response state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            count       <= '0;
            acc         <= '0;
            q           <= '0;
            e           <= 1'b0;
            y_reg       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_z_r     <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        q        <= sel_x;
                        y_reg    <= sel_y;
                        rsp_id_r <= grant_id;
                        acc      <= '0;
                        e        <= 1'b0;
                        count    <= '0;
                        rr_ptr   <= ~grant_id;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    e     <= e_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        rsp_valid_r <= 1'b1;
                        rsp_z_r     <= prod_next;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOOTH_SCHED_STATS_EN
    // Per-requester count of accepted responses, wrapping at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (rsp_valid_r && bus.rsp_ready) begin
            if (rsp_id_r) begin
                stat_cnt1 <= stat_cnt1 + 8'd1;
            end else begin
                stat_cnt0 <= stat_cnt0 + 8'd1;
            end
        end
    end
`endif

endmodule
